// File: rtl/usb_app_pkg.sv
// Shared constants and types for the USB application-side OUT endpoint logic.
// Holds the frame SYNC value, the parser state encoding and the status-bit default.
package usb_app_pkg;

  localparam logic [7:0] SYNC_BYTE         = 8'hA5;
  localparam int         EMPTY_BIT_DEFAULT = 1;
  localparam int         STAT_W            = 4;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CSUM    = 2'd3
  } parse_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ep_out_parser_if.sv
// Bundle of the OUT-endpoint FIFO read port, the payload stream and the frame status.
// master = parser side, slave = FIFO/sink/environment side.
interface ep_out_parser_if;
  import usb_app_pkg::*;

  logic [7:0]        ep_dout;
  logic              ep_re;
  logic [STAT_W-1:0] ep_stat;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              pkt_ok;
  logic              pkt_err;
  logic [7:0]        good_cnt;
  logic [7:0]        err_cnt;

  modport master (
    input  ep_dout, ep_stat, out_ready,
    output ep_re, out_data, out_valid, out_last, pkt_ok, pkt_err, good_cnt, err_cnt
  );

  modport slave (
    output ep_dout, ep_stat, out_ready,
    input  ep_re, out_data, out_valid, out_last, pkt_ok, pkt_err, good_cnt, err_cnt
  );

endinterface

// File: rtl/ep_fifo_reader.sv
// Issues single-byte FIFO reads and presents the returned byte for one cycle.
// A read is issued only when the consumer can take the byte on the following cycle.
module ep_fifo_reader (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       fifo_empty_i,
  input  logic [7:0] ep_dout_i,
  input  logic       byte_ready_i,
  output logic       ep_re_o,
  output logic       byte_valid_o,
  output logic [7:0] byte_o
);

  logic armed_q;
  logic pend_q;

  // armed_q keeps the strobe low while reset is held and for the first cycle after it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      armed_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      pend_q  <= ep_re_o;
    end
  end

  assign ep_re_o      = armed_q && !fifo_empty_i && byte_ready_i;
  assign byte_valid_o = pend_q;
  assign byte_o       = ep_dout_i;

endmodule

// File: rtl/ep_out_parser.sv
// Frame parser for the OUT endpoint: SYNC, LEN, payload, XOR checksum.
// Forwards payload bytes with valid/ready and reports each frame's checksum status.
module ep_out_parser
  import usb_app_pkg::*;
#(
  parameter int MAX_LEN   = 64,
  parameter int EMPTY_BIT = EMPTY_BIT_DEFAULT
) (
  input  logic           clk_i,
  input  logic           rst_i,
  ep_out_parser_if.master bus
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  parse_state_e state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [7:0]   xor_q, xor_d;
  logic [7:0]   out_data_q, out_data_d;
  logic         out_valid_q, out_valid_d;
  logic         out_last_q, out_last_d;
  logic         pkt_ok_q, pkt_ok_d;
  logic         pkt_err_q, pkt_err_d;
  logic [7:0]   good_q, good_d;
  logic [7:0]   err_q, err_d;

  logic         byte_valid;
  logic [7:0]   byte_in;
  logic         byte_ready;
  logic         ep_re;

  // A captured payload byte occupies the output register next cycle, so no read is
  // launched alongside it; otherwise a read waits only for the output to drain.
  assign byte_ready = (!out_valid_q || bus.out_ready) &&
                      !(byte_valid && (state_q == ST_PAYLOAD));

  ep_fifo_reader u_reader (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .fifo_empty_i(bus.ep_stat[EMPTY_BIT]),
    .ep_dout_i   (bus.ep_dout),
    .byte_ready_i(byte_ready),
    .ep_re_o     (ep_re),
    .byte_valid_o(byte_valid),
    .byte_o      (byte_in)
  );

  // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    xor_d       = xor_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    out_last_d  = out_last_q && out_valid_d;
    pkt_ok_d    = 1'b0;
    pkt_err_d   = 1'b0;
    good_d      = good_q;
    err_d       = err_q;

    if (byte_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (byte_in == SYNC_BYTE) state_d = ST_LEN;
        end
        ST_LEN: begin
          xor_d = byte_in;
          cnt_d = byte_in;
          if (byte_in == 8'd0) begin
            state_d = ST_CSUM;
          end else if (byte_in > MAX_LEN_B) begin
            pkt_err_d = 1'b1;
            err_d     = sat_inc8(err_q);
            state_d   = ST_HUNT;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          out_data_d  = byte_in;
          out_valid_d = 1'b1;
          out_last_d  = (cnt_q == 8'd1);
          xor_d       = xor_q ^ byte_in;
          cnt_d       = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = ST_CSUM;
        end
        ST_CSUM: begin
          if (byte_in == xor_q) begin
            pkt_ok_d = 1'b1;
            good_d   = good_q + 8'd1;
          end else begin
            pkt_err_d = 1'b1;
            err_d     = sat_inc8(err_q);
          end
          state_d = ST_HUNT;
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_HUNT;
      cnt_q       <= 8'd0;
      xor_q       <= 8'd0;
      out_data_q  <= 8'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      pkt_ok_q    <= 1'b0;
      pkt_err_q   <= 1'b0;
      good_q      <= 8'd0;
      err_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      xor_q       <= xor_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      pkt_ok_q    <= pkt_ok_d;
      pkt_err_q   <= pkt_err_d;
      good_q      <= good_d;
      err_q       <= err_d;
    end
  end

  assign bus.ep_re     = ep_re;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.pkt_ok    = pkt_ok_q;
  assign bus.pkt_err   = pkt_err_q;
  assign bus.good_cnt  = good_q;
  assign bus.err_cnt   = err_q;

endmodule
